// File: rtl/lane_detect_counter.sv
// lane_detect_counter: synchronise, debounce and edge-detect four loop detectors, then keep
// saturating running totals and per-phase window counts. Define LANE_STUCK_EN for stuck flags.
module lane_detect_counter #(
  parameter int unsigned DEB_CYCLES   = 500_000,
  parameter int unsigned TOT_MAX      = 9999,
  parameter int unsigned TOT_W        = 14,
  parameter int unsigned WIN_W        = 4,
  parameter int unsigned STUCK_CYCLES = 3_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           detect,
  input  logic [3:0]           win_clr,
  output logic [3:0]           car_pulse,
  output logic [4*TOT_W-1:0]   count_total,
  output logic [4*WIN_W-1:0]   count_win,
  output logic [3:0]           stuck
);

  localparam int unsigned DebW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DebW-1:0]  DebLast = DebW'(DEB_CYCLES - 1);
  localparam logic [TOT_W-1:0] TotMax  = TOT_W'(TOT_MAX);
  localparam logic [WIN_W-1:0] WinMax  = '1;

  if ((TOT_MAX >> TOT_W) != 0 || DEB_CYCLES == 0 || STUCK_CYCLES == 0) begin : g_param_err
    $error("lane_detect_counter: illegal parameter combination");
  end

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       stable_q, stable_d, stable_dly_q, pulse_q;
  logic [DebW-1:0]  deb_cnt_q [4];
  logic [DebW-1:0]  deb_cnt_d [4];
  logic [TOT_W-1:0] total_q [4];
  logic [TOT_W-1:0] total_d [4];
  logic [WIN_W-1:0] win_q [4];
  logic [WIN_W-1:0] win_d [4];

  // Timer runs only while the synchronised level disagrees with the accepted one.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          stable_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      total_d[i] = total_q[i];
      win_d[i]   = win_q[i];
      if (pulse_q[i] && (total_q[i] != TotMax)) begin
        total_d[i] = total_q[i] + 1'b1;
      end
      // A car arriving with the phase change belongs to the new phase.
      if (win_clr[i]) begin
        win_d[i] = pulse_q[i] ? WIN_W'(1) : '0;
      end else if (pulse_q[i] && (win_q[i] != WinMax)) begin
        win_d[i] = win_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      pulse_q      <= '0;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= '0;
        total_q[i]   <= '0;
        win_q[i]     <= '0;
      end
    end else begin
      sync1_q      <= detect;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      pulse_q      <= stable_q & ~stable_dly_q;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        total_q[i]   <= total_d[i];
        win_q[i]     <= win_d[i];
      end
    end
  end

  always_comb begin
    car_pulse   = pulse_q;
    count_total = '0;
    count_win   = '0;
    for (int i = 0; i < 4; i++) begin
      count_total[i*TOT_W +: TOT_W] = total_q[i];
      count_win[i*WIN_W +: WIN_W]   = win_q[i];
    end
  end

`ifdef LANE_STUCK_EN
  localparam int unsigned StuckW = (STUCK_CYCLES > 2) ? $clog2(STUCK_CYCLES) : 1;
  localparam logic [StuckW-1:0] StuckLast = StuckW'(STUCK_CYCLES - 1);

  logic [StuckW-1:0] stuck_cnt_q [4];
  logic [StuckW-1:0] stuck_cnt_d [4];
  logic [3:0]        stuck_q, stuck_d;

  // Timer saturates once the flag is raised; a debounced low clears both.
  always_comb begin
    stuck_d = stuck_q;
    for (int i = 0; i < 4; i++) begin
      stuck_cnt_d[i] = stuck_cnt_q[i];
      if (!stable_q[i]) begin
        stuck_cnt_d[i] = '0;
        stuck_d[i]     = 1'b0;
      end else if (stuck_cnt_q[i] == StuckLast) begin
        stuck_d[i] = 1'b1;
      end else begin
        stuck_cnt_d[i] = stuck_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stuck_q <= '0;
      for (int i = 0; i < 4; i++) begin
        stuck_cnt_q[i] <= '0;
      end
    end else begin
      stuck_q <= stuck_d;
      for (int i = 0; i < 4; i++) begin
        stuck_cnt_q[i] <= stuck_cnt_d[i];
      end
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 4'b0000;
`endif

endmodule
